// File: rtl/e203_exu_alu_rglr_q_pkg.sv
// Shared definitions for the regular-ALU issue/writeback stage: info-bus field
// positions, default info width and the commit-flag part of a queued result.
package e203_exu_alu_rglr_pkg;

  localparam int unsigned RGLR_INFO_W = 17;

  localparam int unsigned OP2IMM = 0;
  localparam int unsigned OP1PC  = 1;
  localparam int unsigned NOP    = 2;
  localparam int unsigned ADD    = 3;
  localparam int unsigned SUB    = 4;
  localparam int unsigned XOR    = 5;
  localparam int unsigned SLL    = 6;
  localparam int unsigned SRL    = 7;
  localparam int unsigned SRA    = 8;
  localparam int unsigned OR     = 9;
  localparam int unsigned AND    = 10;
  localparam int unsigned SLT    = 11;
  localparam int unsigned SLTU   = 12;
  localparam int unsigned LUI    = 13;
  localparam int unsigned ECAL   = 14;
  localparam int unsigned EBRK   = 15;
  localparam int unsigned WFI    = 16;

  // Low bits of every queue entry; the XLEN-wide result sits above it.
  typedef struct packed {
    logic err;
    logic ecall;
    logic ebreak;
    logic wfi;
  } rglr_cmt_t;

endpackage

// File: rtl/e203_exu_alu_rglr_q_if.sv
// Issue, writeback and datapath-request bundle of the regular-ALU stage.
// master = dispatch/datapath side, slave = the stage itself.
interface e203_exu_alu_rglr_q_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_SIZE = 32,
  parameter int unsigned INFO_W  = e203_exu_alu_rglr_pkg::RGLR_INFO_W
);
  logic              alu_i_valid;
  logic              alu_i_ready;
  logic [XLEN-1:0]   alu_i_rs1;
  logic [XLEN-1:0]   alu_i_rs2;
  logic [XLEN-1:0]   alu_i_imm;
  logic [PC_SIZE-1:0] alu_i_pc;
  logic [INFO_W-1:0] alu_i_info;
  logic              alu_i_flush;

  logic              alu_o_valid;
  logic              alu_o_ready;
  logic [XLEN-1:0]   alu_o_wbck_wdat;
  logic              alu_o_wbck_err;
  logic              alu_o_cmt_ecall;
  logic              alu_o_cmt_ebreak;
  logic              alu_o_cmt_wfi;

  logic alu_req_alu_add, alu_req_alu_sub, alu_req_alu_xor, alu_req_alu_sll;
  logic alu_req_alu_srl, alu_req_alu_sra, alu_req_alu_or,  alu_req_alu_and;
  logic alu_req_alu_slt, alu_req_alu_sltu, alu_req_alu_lui;
  logic [XLEN-1:0]   alu_req_alu_op1;
  logic [XLEN-1:0]   alu_req_alu_op2;
  logic [XLEN-1:0]   alu_req_alu_res;

  modport master (
    output alu_i_valid, alu_i_rs1, alu_i_rs2, alu_i_imm, alu_i_pc, alu_i_info,
           alu_i_flush, alu_o_ready, alu_req_alu_res,
    input  alu_i_ready, alu_o_valid, alu_o_wbck_wdat, alu_o_wbck_err,
           alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi,
           alu_req_alu_add, alu_req_alu_sub, alu_req_alu_xor, alu_req_alu_sll,
           alu_req_alu_srl, alu_req_alu_sra, alu_req_alu_or, alu_req_alu_and,
           alu_req_alu_slt, alu_req_alu_sltu, alu_req_alu_lui,
           alu_req_alu_op1, alu_req_alu_op2
  );

  modport slave (
    input  alu_i_valid, alu_i_rs1, alu_i_rs2, alu_i_imm, alu_i_pc, alu_i_info,
           alu_i_flush, alu_o_ready, alu_req_alu_res,
    output alu_i_ready, alu_o_valid, alu_o_wbck_wdat, alu_o_wbck_err,
           alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi,
           alu_req_alu_add, alu_req_alu_sub, alu_req_alu_xor, alu_req_alu_sll,
           alu_req_alu_srl, alu_req_alu_sra, alu_req_alu_or, alu_req_alu_and,
           alu_req_alu_slt, alu_req_alu_sltu, alu_req_alu_lui,
           alu_req_alu_op1, alu_req_alu_op2
  );

endinterface

// File: rtl/e203_exu_alu_rglr_q_fifo.sv
// Generic DEPTH x W queue with synchronous flush; DEPTH need not be a power of 2.
// Storage is not reset; only pointers and count are.
module e203_exu_alu_rglr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_en, pop_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i & ~full_o & ~flush_i;
  assign pop_en  = pop_i & ~empty_o & ~flush_i;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_en) wptr_d = ptr_inc(wptr_q);
      if (pop_en)  rptr_d = ptr_inc(rptr_q);
      case ({push_en, pop_en})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/e203_exu_alu_rglr_q.sv
// Regular-ALU issue/writeback stage with a DEPTH-entry writeback queue.
// Optional same-cycle bypass when empty: define E203_ALU_RGLR_Q_BYPASS_EN.
module e203_exu_alu_rglr_q
  import e203_exu_alu_rglr_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_SIZE = 32,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned INFO_W  = RGLR_INFO_W
) (
  input logic                  clk,
  input logic                  rst_n,
  e203_exu_alu_rglr_q_if.slave bus
);
  localparam int unsigned EW = XLEN + $bits(rglr_cmt_t);

  logic [INFO_W-1:0] info;
  logic              vld, is_nop;
  rglr_cmt_t         cmt_in, cmt_out;
  logic [XLEN-1:0]   wdat_in, wdat_out;
  logic [EW-1:0]     entry_in, entry_q, entry_out;
  logic              full, empty, push, pop, bypass;

  assign info   = bus.alu_i_info;
  assign vld    = bus.alu_i_valid;
  assign is_nop = info[NOP];

  // NOP rides the adder with both operands zeroed.
  assign bus.alu_req_alu_add  = vld & (info[ADD] | is_nop);
  assign bus.alu_req_alu_sub  = vld & info[SUB];
  assign bus.alu_req_alu_xor  = vld & info[XOR];
  assign bus.alu_req_alu_sll  = vld & info[SLL];
  assign bus.alu_req_alu_srl  = vld & info[SRL];
  assign bus.alu_req_alu_sra  = vld & info[SRA];
  assign bus.alu_req_alu_or   = vld & info[OR];
  assign bus.alu_req_alu_and  = vld & info[AND];
  assign bus.alu_req_alu_slt  = vld & info[SLT];
  assign bus.alu_req_alu_sltu = vld & info[SLTU];
  assign bus.alu_req_alu_lui  = vld & info[LUI];

  assign bus.alu_req_alu_op1 = is_nop      ? '0 :
                               info[OP1PC]  ? XLEN'(bus.alu_i_pc) : bus.alu_i_rs1;
  assign bus.alu_req_alu_op2 = is_nop      ? '0 :
                               info[OP2IMM] ? bus.alu_i_imm : bus.alu_i_rs2;

  always_comb begin
    cmt_in        = '0;
    cmt_in.ecall  = info[ECAL];
    cmt_in.ebreak = info[EBRK];
    cmt_in.wfi    = info[WFI];
    cmt_in.err    = info[ECAL] | info[EBRK] | info[WFI];
  end

  assign wdat_in  = cmt_in.err ? '0 : bus.alu_req_alu_res;
  assign entry_in = {wdat_in, cmt_in};

`ifdef E203_ALU_RGLR_Q_BYPASS_EN
  assign bypass = empty & bus.alu_o_ready & ~bus.alu_i_flush;
`else
  assign bypass = 1'b0;
`endif

  assign bus.alu_i_ready = ~full & ~bus.alu_i_flush;
  assign push            = vld & bus.alu_i_ready & ~bypass;
  assign bus.alu_o_valid = bypass ? vld : ~empty;
  assign pop             = bus.alu_o_valid & bus.alu_o_ready;
  assign entry_out       = bypass ? entry_in : entry_q;
  assign {wdat_out, cmt_out} = entry_out;

  assign bus.alu_o_wbck_wdat  = wdat_out;
  assign bus.alu_o_wbck_err   = cmt_out.err;
  assign bus.alu_o_cmt_ecall  = cmt_out.ecall;
  assign bus.alu_o_cmt_ebreak = cmt_out.ebreak;
  assign bus.alu_o_cmt_wfi    = cmt_out.wfi;

  e203_exu_alu_rglr_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.alu_i_flush),
    .push_i  (push),
    .wdata_i (entry_in),
    .pop_i   (pop),
    .rdata_o (entry_q),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_e203_exu_alu_rglr_q.sv
// Self-checking bench: directed scenarios then random traffic against a
// queue-based reference model of the regular-ALU stage.
module tb_e203_exu_alu_rglr_q;
  import e203_exu_alu_rglr_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [35:0] mq [$];
  logic [31:0] dp_res;

  always #5 clk = ~clk;

  e203_exu_alu_rglr_q_if #(.XLEN(XLEN), .PC_SIZE(32), .INFO_W(RGLR_INFO_W)) bus ();

  e203_exu_alu_rglr_q #(
    .XLEN    (XLEN),
    .PC_SIZE (32),
    .DEPTH   (DEPTH),
    .INFO_W  (RGLR_INFO_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] alu_fn(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ADD, NOP: return a + b;
      SUB:  return a - b;
      XOR:  return a ^ b;
      SLL:  return a << b[4:0];
      SRL:  return a >> b[4:0];
      SRA:  return 32'($signed(a) >>> b[4:0]);
      OR:   return a | b;
      AND:  return a & b;
      SLT:  return {31'b0, $signed(a) < $signed(b)};
      SLTU: return {31'b0, a < b};
      LUI:  return b;
      default: return 32'h0;
    endcase
  endfunction

  // Shared datapath stand-in: answers whichever request is raised.
  always_comb begin
    dp_res = '0;
    if      (bus.alu_req_alu_add)  dp_res = alu_fn(ADD,  bus.alu_req_alu_op1, bus.alu_req_alu_op2);
    else if (bus.alu_req_alu_sub)  dp_res = alu_fn(SUB,  bus.alu_req_alu_op1, bus.alu_req_alu_op2);
    else if (bus.alu_req_alu_xor)  dp_res = alu_fn(XOR,  bus.alu_req_alu_op1, bus.alu_req_alu_op2);
    else if (bus.alu_req_alu_sll)  dp_res = alu_fn(SLL,  bus.alu_req_alu_op1, bus.alu_req_alu_op2);
    else if (bus.alu_req_alu_srl)  dp_res = alu_fn(SRL,  bus.alu_req_alu_op1, bus.alu_req_alu_op2);
    else if (bus.alu_req_alu_sra)  dp_res = alu_fn(SRA,  bus.alu_req_alu_op1, bus.alu_req_alu_op2);
    else if (bus.alu_req_alu_or)   dp_res = alu_fn(OR,   bus.alu_req_alu_op1, bus.alu_req_alu_op2);
    else if (bus.alu_req_alu_and)  dp_res = alu_fn(AND,  bus.alu_req_alu_op1, bus.alu_req_alu_op2);
    else if (bus.alu_req_alu_slt)  dp_res = alu_fn(SLT,  bus.alu_req_alu_op1, bus.alu_req_alu_op2);
    else if (bus.alu_req_alu_sltu) dp_res = alu_fn(SLTU, bus.alu_req_alu_op1, bus.alu_req_alu_op2);
    else if (bus.alu_req_alu_lui)  dp_res = alu_fn(LUI,  bus.alu_req_alu_op1, bus.alu_req_alu_op2);
  end
  assign bus.alu_req_alu_res = dp_res;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [35:0] exp_entry(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ECAL:    return {32'h0, 4'b1100};
      EBRK:    return {32'h0, 4'b1010};
      WFI:     return {32'h0, 4'b1001};
      default: return {alu_fn(op, a, b), 4'b0000};
    endcase
  endfunction

  // Drive one cycle of stimulus, check at negedge, update the model, advance.
  task automatic step(input logic v, input int unsigned op, input logic p1, input logic i2,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                      input logic [31:0] pcv, input logic ordy, input logic fl);
    logic [16:0] info;
    logic [31:0] ea, eb;
    logic [10:0] ereq, dreq;
    logic [35:0] ent, dout;
    logic        erdy, byp;
    info = '0;
    info[op] = 1'b1;
    info[OP1PC] = p1;
    info[OP2IMM] = i2;
    bus.alu_i_valid = v;
    bus.alu_i_info  = info;
    bus.alu_i_rs1   = a;
    bus.alu_i_rs2   = b;
    bus.alu_i_imm   = im;
    bus.alu_i_pc    = pcv;
    bus.alu_o_ready = ordy;
    bus.alu_i_flush = fl;
    @(negedge clk);
    ea   = (op == NOP) ? 32'h0 : (p1 ? pcv : a);
    eb   = (op == NOP) ? 32'h0 : (i2 ? im : b);
    ereq = '0;
    if (v && op == NOP) ereq[0] = 1'b1;
    else if (v && op >= ADD && op <= LUI) ereq[op - ADD] = 1'b1;
    ent  = exp_entry(op, ea, eb);
    erdy = (mq.size() < DEPTH) && !fl;
`ifdef E203_ALU_RGLR_Q_BYPASS_EN
    byp = (mq.size() == 0) && ordy && !fl;
`else
    byp = 1'b0;
`endif
    dreq = {bus.alu_req_alu_lui, bus.alu_req_alu_sltu, bus.alu_req_alu_slt, bus.alu_req_alu_and,
            bus.alu_req_alu_or, bus.alu_req_alu_sra, bus.alu_req_alu_srl, bus.alu_req_alu_sll,
            bus.alu_req_alu_xor, bus.alu_req_alu_sub, bus.alu_req_alu_add};
    dout = {bus.alu_o_wbck_wdat, bus.alu_o_wbck_err, bus.alu_o_cmt_ecall,
            bus.alu_o_cmt_ebreak, bus.alu_o_cmt_wfi};
    chk_eq("req_vec", 64'(dreq), 64'(ereq));
    chk_eq("op1", 64'(bus.alu_req_alu_op1), 64'(ea));
    chk_eq("op2", 64'(bus.alu_req_alu_op2), 64'(eb));
    chk_eq("i_ready", 64'(bus.alu_i_ready), 64'(erdy));
    if (byp) begin
      chk_eq("o_valid_byp", 64'(bus.alu_o_valid), 64'(v));
      if (v) chk_eq("o_data_byp", 64'(dout), 64'(ent));
    end else begin
      chk_eq("o_valid", 64'(bus.alu_o_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) chk_eq("o_data", 64'(dout), 64'(mq[0]));
    end
    if (fl) begin
      mq.delete();
    end else begin
      if (!byp && mq.size() != 0 && ordy) void'(mq.pop_front());
      if (v && erdy && !byp) mq.push_back(ent);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, ADD, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  initial begin
    bus.alu_i_valid = 1'b0;
    bus.alu_i_info  = '0;
    bus.alu_i_rs1   = '0;
    bus.alu_i_rs2   = '0;
    bus.alu_i_imm   = '0;
    bus.alu_i_pc    = '0;
    bus.alu_i_flush = 1'b0;
    bus.alu_o_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_o_valid", 64'(bus.alu_o_valid), 64'd0);
    chk_eq("rst_i_ready", 64'(bus.alu_i_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD 5 + 7 then observe one cycle later
    step(1'b1, ADD, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    chk_eq("add_valid", 64'(bus.alu_o_valid), 64'd1);
    chk_eq("add_wdat", 64'(bus.alu_o_wbck_wdat), 64'd12);
    idle(1'b1);

    step(1'b1, ADD, 1'b1, 1'b1, 32'h1111, 32'h2222, 32'd4, 32'h8000_0000, 1'b0, 1'b0);
    chk_eq("pcimm_wdat", 64'(bus.alu_o_wbck_wdat), 64'h8000_0004);
    idle(1'b1);
    step(1'b1, ECAL, 1'b0, 1'b0, 32'h33, 32'h44, 32'd0, 32'd0, 1'b0, 1'b0);
    chk_eq("ecal_err", 64'(bus.alu_o_wbck_err), 64'd1);
    chk_eq("ecal_flag", 64'(bus.alu_o_cmt_ecall), 64'd1);
    chk_eq("ecal_wdat", 64'(bus.alu_o_wbck_wdat), 64'd0);
    idle(1'b1);

    // Fill to DEPTH, hold one extra issue until space frees up
    for (int unsigned k = 0; k < DEPTH; k++)
      step(1'b1, SUB, 1'b0, 1'b0, 32'd100 + k, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, XOR, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk_eq("full_ready", 64'(bus.alu_i_ready), 64'd0);
    step(1'b1, XOR, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b1, XOR, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (DEPTH + 1) idle(1'b1);

    // Continuous push/pop so pointers wrap a non-power-of-2 depth
    for (int unsigned k = 0; k < 10; k++)
      step(1'b1, SLL, 1'b0, 1'b1, 32'd1 + k, 32'd0, k, 32'd0, 1'b1, 1'b0);
    idle(1'b1);

    // Flush with two queued entries plus a concurrent issue and pop
    step(1'b1, OR, 1'b0, 1'b0, 32'h1, 32'h2, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, AND, 1'b0, 1'b0, 32'h3, 32'h6, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, LUI, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1234_5000, 32'd0, 1'b1, 1'b1);
    chk_eq("flush_valid", 64'(bus.alu_o_valid), 64'd0);
    idle(1'b1);

    // Asynchronous reset with queued entries
    step(1'b1, SRA, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, SLT, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.alu_i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_valid", 64'(bus.alu_o_valid), 64'd0);
    chk_eq("arst_ready", 64'(bus.alu_i_ready), 64'd1);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int unsigned n = 0; n < 500; n++) begin
      step(($urandom % 4) != 0, $urandom_range(WFI, NOP), 1'($urandom), 1'($urandom),
           $urandom, $urandom, $urandom, $urandom,
           ($urandom % 8) < 5, ($urandom % 25) == 0);
    end
    repeat (DEPTH + 1) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/e203_exu_alu_rglr_q.md
# e203_exu_alu_rglr_q

Parametrised regular-ALU issue/writeback stage for the E203 EXU. It decodes the regular-ALU info bus into requests for the shared ALU datapath and captures each result with its commit flags. Results are buffered in a DEPTH-entry writeback queue, so a stalled writeback port no longer back-pressures the issue port until the queue is full. It sits between the EXU dispatch and the ALU writeback/commit arbiters and replaces the unbuffered regular-ALU path.

## Interface
Parameters:
- XLEN, 32: datapath width.
- PC_SIZE, 32: PC width; must be ≤ XLEN.
- DEPTH, 2: writeback queue entries, ≥1, any integer (not only powers of 2).
- INFO_W, 17: info bus width; field positions come from the package.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_i_valid / alu_i_ready  in/out  1  issue handshake
- alu_i_rs1, alu_i_rs2, alu_i_imm  in  XLEN  operands
- alu_i_pc  in  PC_SIZE  instruction PC
- alu_i_info  in  INFO_W  decoded op fields
- alu_i_flush  in  1  discard all queued results
- alu_o_valid / alu_o_ready  out/in  1  writeback handshake
- alu_o_wbck_wdat  out  XLEN  result
- alu_o_wbck_err, alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi  out  1  commit flags
- alu_req_alu_{add,sub,xor,sll,srl,sra,or,and,slt,sltu,lui}  out  1  datapath op requests
- alu_req_alu_op1, alu_req_alu_op2  out  XLEN  datapath operands
- alu_req_alu_res  in  XLEN  datapath result, same cycle as request

## Operation
- Requests are combinational. Each alu_req_alu_<op> = alu_i_valid & info[<OP>].
- op1 = OP1PC ? zero-extended pc : rs1. op2 = OP2IMM ? imm : rs2.
- NOP forces add with op1 = op2 = 0.
- Commit flags come from info ECAL/EBRK/WFI. err = ecall | ebreak | wfi; wdat is then 0.
- A push happens on alu_i_valid & alu_i_ready. The entry {res, err, ecall, ebreak, wfi} is written at wptr.
- A pop happens on alu_o_valid & alu_o_ready.
- Pointers wrap from DEPTH-1 to 0. cnt is 0..DEPTH; full = (cnt == DEPTH); empty = (cnt == 0).
- alu_i_ready = ~full. There is no push-through-pop when full, which keeps in→out ready free of combinational paths.
- alu_o_valid = ~empty. Outputs show the entry at rptr.
- Simultaneous push and pop (not full, not empty): cnt is unchanged and both pointers advance.
- alu_i_flush has priority over everything:
  - next cycle cnt = 0 and wptr = rptr = 0;
  - a same-cycle push or pop is discarded;
  - alu_i_ready is forced to 0 in the flush cycle.

## Timing
- Reset values:
  - alu_o_valid = 0, alu_i_ready = 1;
  - cnt, wptr, rptr = 0;
  - storage is not reset, so alu_o_wbck_* are X/don't-care while alu_o_valid = 0.
- Issue-to-writeback latency is 1 cycle when the queue is empty (without bypass).
- Throughput is 1/cycle while alu_o_ready is held high.
- alu_o_valid must stay high and the data stable until the pop. This holds by construction.
- Reset mid-operation drops all entries immediately and asynchronously.

## Configuration
- E203_ALU_RGLR_Q_BYPASS_EN defined:
  - when empty & alu_o_ready & ~alu_i_flush, the incoming result drives the outputs combinationally with alu_o_valid = alu_i_valid;
  - no push occurs, giving zero latency;
  - alu_i_ready is still ~full (which is true when empty).
- Undefined: all results go through the queue, with 1-cycle minimum latency and no in→out combinational path.

## Structure
- Package e203_exu_alu_rglr_pkg holds:
  - INFO field index constants: OP2IMM, OP1PC, NOP, ADD, SUB, XOR, SLL, SRL, SRA, OR, AND, SLT, SLTU, LUI, ECAL, EBRK, WFI;
  - INFO_W default;
  - the result-entry struct typedef.
- Sub-module e203_exu_alu_rglr_fifo: generic DEPTH×W queue with flush, pointer wrap and cnt.

## Test plan
- Reset → alu_o_valid = 0, alu_i_ready = 1. Then ADD rs1 = 5, rs2 = 7 with res = 12 → alu_req_alu_add = 1, op1 = 5, op2 = 7; next cycle alu_o_valid = 1, wdat = 12.
- OP1PC + OP2IMM with pc = 0x80000000, imm = 4 → op1 = 0x80000000, op2 = 4. ECAL alone → err = 1, ecall = 1, wdat = 0.
- DEPTH = 2, alu_o_ready = 0, three back-to-back issues → two accepted, alu_i_ready = 0 on the third. Raising alu_o_ready → results pop in order, then the third is accepted.
- DEPTH = 3, continuous push and pop for 10 ops → pointers wrap, order is preserved, cnt stays at 1.
- Queue holding 2 entries, flush asserted together with valid issue and pop → next cycle alu_o_valid = 0, cnt = 0, and the issued op is dropped.
- With BYPASS_EN, empty queue, alu_o_ready = 1, ADD → alu_o_valid in the same cycle with wdat = res and no push. Without it → 1-cycle latency.
